// File: rtl/frame_buffer_scanner_if.sv
// Pixel stream carried from frame_buffer_scanner to the display serializer.
// master: the scanner (drives pixel, valid and markers); slave: the sink (drives ready).
interface frame_buffer_scanner_if;
    logic [3:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic       pix_sof;
    logic       pix_eol;

    modport master (output pix_data, output pix_valid, output pix_sof, output pix_eol,
                    input  pix_ready);
    modport slave  (input  pix_data, input  pix_valid, input  pix_sof, input  pix_eol,
                    output pix_ready);
endinterface

// File: rtl/frame_buffer_scanner.sv
// Raster read engine for a 4-bit frame buffer. Walks the buffer in raster order, absorbs
// the 1-cycle RAM read latency and emits pixels with sof/eol markers through a skid FIFO.
// Optional feature macro: FB_SCANNER_TEST_PATTERN_EN (adds test_pattern input, 8 colour bars).
module frame_buffer_scanner #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 400,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef FB_SCANNER_TEST_PATTERN_EN
    input  logic        test_pattern,
`endif
    input  logic        fb_ready,
    output logic [17:0] fb_rd_addr,
    input  logic [3:0]  fb_rd_data,
    output logic        busy,
    output logic        frame_done,
    frame_buffer_scanner_if.master pix
);

    localparam int unsigned TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int unsigned XW    = $clog2(H_ACTIVE);
    localparam int unsigned YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = PW + 1;

    typedef enum logic [1:0] {StIdle, StWaitRdy, StScan, StDrain} state_e;

    state_e        state_q, state_d;
    logic [17:0]   next_addr_q, next_addr_d;   // address of the next read to issue
    logic [17:0]   last_addr_q, last_addr_d;   // address of the most recent read issued
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          inflight_q, inflight_d;
    logic          sof_q, sof_d;               // markers of the read in flight
    logic          eol_q, eol_d;
    logic          frame_done_q, frame_done_d;
    logic [5:0]    mem_q [FIFO_DEPTH];         // {sof, eol, pixel}
    logic [5:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          issue;
    logic          fifo_valid;
    logic          hs;
    logic          final_hs;
    logic [3:0]    wr_pix;
    logic [5:0]    rd_word;

`ifdef FB_SCANNER_TEST_PATTERN_EN
    localparam int unsigned BAR_W = $clog2(H_ACTIVE / 8 + 1);
    logic             tp_q, tp_d;
    logic [BAR_W-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic [2:0]       bar_wr_q, bar_wr_d;      // bar index of the read in flight
`endif

    // Issue gating: FIFO entries plus the read in flight must leave room for one more.
    always_comb begin
        fifo_valid = (count_q != '0);
        hs         = fifo_valid & pix.pix_ready;
        issue      = (state_q == StScan) && ((count_q + CW'(inflight_q)) < CW'(FIFO_DEPTH));
        final_hs   = (state_q == StDrain) && hs && !inflight_q && (count_q == CW'(1));
    end

    // Frame sequencing, address and raster position counters.
    always_comb begin
        state_d      = state_q;
        next_addr_d  = next_addr_q;
        last_addr_d  = last_addr_q;
        x_d          = x_q;
        y_d          = y_q;
        sof_d        = sof_q;
        eol_d        = eol_q;
        inflight_d   = issue;
        frame_done_d = 1'b0;
`ifdef FB_SCANNER_TEST_PATTERN_EN
        tp_d         = tp_q;
        bar_cnt_d    = bar_cnt_q;
        bar_idx_d    = bar_idx_q;
        bar_wr_d     = bar_wr_q;
`endif
        case (state_q)
            StIdle: begin
                // The frame_done cycle still counts as the tail of the previous frame.
                if (start && !frame_done_q) begin
                    state_d     = fb_ready ? StScan : StWaitRdy;
                    next_addr_d = '0;
                    x_d         = '0;
                    y_d         = '0;
`ifdef FB_SCANNER_TEST_PATTERN_EN
                    tp_d        = test_pattern;
                    bar_cnt_d   = '0;
                    bar_idx_d   = '0;
`endif
                end
            end
            StWaitRdy: if (fb_ready) state_d = StScan;
            StScan:    if (issue && (next_addr_q == 18'(TOTAL - 1))) state_d = StDrain;
            StDrain: begin
                if (final_hs) begin
                    state_d      = StIdle;
                    frame_done_d = 1'b1;
                    last_addr_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (issue) begin
            last_addr_d = next_addr_q;
            next_addr_d = next_addr_q + 18'd1;
            sof_d       = (x_q == '0) && (y_q == '0);
            eol_d       = (x_q == XW'(H_ACTIVE - 1));
            if (x_q == XW'(H_ACTIVE - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(V_ACTIVE - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
`ifdef FB_SCANNER_TEST_PATTERN_EN
            bar_wr_d = bar_idx_q;
            if (x_q == XW'(H_ACTIVE - 1)) begin
                bar_cnt_d = '0;
                bar_idx_d = '0;
            end else if (bar_cnt_q == BAR_W'(H_ACTIVE / 8 - 1)) begin
                bar_cnt_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + BAR_W'(1);
            end
`endif
        end
    end

    // Skid FIFO: returning read data is written, handshakes pop.
    always_comb begin
`ifdef FB_SCANNER_TEST_PATTERN_EN
        wr_pix = tp_q ? {1'b0, bar_wr_q} : fb_rd_data;
`else
        wr_pix = fb_rd_data;
`endif
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (inflight_q) begin
            mem_d[wr_ptr_q] = {sof_q, eol_q, wr_pix};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (hs) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(inflight_q) - CW'(hs);
    end

    // Outputs: pixel fields read as zero while the FIFO is empty.
    always_comb begin
        rd_word        = fifo_valid ? mem_q[rd_ptr_q] : '0;
        pix.pix_valid  = fifo_valid;
        pix.pix_sof    = rd_word[5];
        pix.pix_eol    = rd_word[4];
        pix.pix_data   = rd_word[3:0];
        fb_rd_addr     = issue ? next_addr_q : last_addr_q;
        busy           = (state_q != StIdle);
        frame_done     = frame_done_q;
    end

    // State register; reset also drops any read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            next_addr_q  <= '0;
            last_addr_q  <= '0;
            x_q          <= '0;
            y_q          <= '0;
            inflight_q   <= 1'b0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            frame_done_q <= 1'b0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
`ifdef FB_SCANNER_TEST_PATTERN_EN
            tp_q         <= 1'b0;
            bar_cnt_q    <= '0;
            bar_idx_q    <= '0;
            bar_wr_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            next_addr_q  <= next_addr_d;
            last_addr_q  <= last_addr_d;
            x_q          <= x_d;
            y_q          <= y_d;
            inflight_q   <= inflight_d;
            sof_q        <= sof_d;
            eol_q        <= eol_d;
            frame_done_q <= frame_done_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
`ifdef FB_SCANNER_TEST_PATTERN_EN
            tp_q         <= tp_d;
            bar_cnt_q    <= bar_cnt_d;
            bar_idx_q    <= bar_idx_d;
            bar_wr_q     <= bar_wr_d;
`endif
        end
    end

endmodule

// File: tb/tb_frame_buffer_scanner.sv
// Self-checking bench for frame_buffer_scanner on a reduced 16x4 frame.
// A pixel-index model predicts every handshaked pixel; directed steps pin cycle timing.
module tb_frame_buffer_scanner;

    localparam int H     = 16;
    localparam int V     = 4;
    localparam int D     = 4;
    localparam int TOTAL = H * V;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        fb_ready = 1'b0;
    logic [17:0] fb_rd_addr;
    logic [3:0]  fb_rd_data = 4'd0;
    logic        busy;
    logic        frame_done;
`ifdef FB_SCANNER_TEST_PATTERN_EN
    logic        test_pattern = 1'b0;
`endif

    frame_buffer_scanner_if pix_if ();

    frame_buffer_scanner #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .FIFO_DEPTH (D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
`ifdef FB_SCANNER_TEST_PATTERN_EN
        .test_pattern (test_pattern),
`endif
        .fb_ready     (fb_ready),
        .fb_rd_addr   (fb_rd_addr),
        .fb_rd_data   (fb_rd_data),
        .busy         (busy),
        .frame_done   (frame_done),
        .pix          (pix_if.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int fb_key = 0;       // buffer content selector, changed only between frames
    bit exp_tp = 1'b0;    // frame expected to carry the colour-bar pattern
    int ready_mode = 1;   // 0: sink stalls, 1: always ready, 2: 30% random

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Buffer contents: low nibble of the address plus key times the line (addr>>4, H=16).
    function automatic logic [3:0] fb_val(input logic [17:0] a);
        return 4'(a[3:0] + 4'(fb_key) * 4'(a >> 4));
    endfunction

    // Expected value of pixel k of a frame, from the raster position.
    function automatic logic [3:0] model_pix(input int k);
        if (exp_tp) return 4'((k % H) / (H / 8));
        return 4'((k % 16) + fb_key * (k / H));
    endfunction

    // Synchronous RAM: data one cycle after its address.
    always @(posedge clk) fb_rd_data <= fb_val(fb_rd_addr);

    // Sink ready driver.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       pix_if.pix_ready = 1'b0;
            1:       pix_if.pix_ready = 1'b1;
            default: pix_if.pix_ready = ($urandom_range(0, 9) < 3);
        endcase
    end

    // Stream compare against the model on every handshake, plus hold-while-stalled checks.
    int         exp_idx = 0;
    bit         stall_prev = 1'b0;
    logic [5:0] prev_word = 6'd0;
    always @(negedge clk) begin
        if (rst) begin
            exp_idx    = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(pix_if.pix_valid), 32'd1);
                chk("hold_word", 32'({pix_if.pix_sof, pix_if.pix_eol, pix_if.pix_data}),
                    32'(prev_word));
            end
            if (pix_if.pix_valid && pix_if.pix_ready) begin
                chk("pix_in_frame", 32'(exp_idx < TOTAL), 32'd1);
                chk("pix_data", 32'(pix_if.pix_data), 32'(model_pix(exp_idx)));
                chk("pix_sof", 32'(pix_if.pix_sof), 32'(exp_idx == 0));
                chk("pix_eol", 32'(pix_if.pix_eol), 32'((exp_idx % H) == H - 1));
                exp_idx++;
            end
            if (frame_done) begin
                chk("done_pixels", 32'(exp_idx), 32'(TOTAL));
                chk("done_busy", 32'(busy), 32'd0);
                exp_idx = 0;
            end
            stall_prev = pix_if.pix_valid && !pix_if.pix_ready;
            prev_word  = {pix_if.pix_sof, pix_if.pix_eol, pix_if.pix_data};
        end
    end

    // Start pulse in "cycle 0"; returns just after the edge that samples it (cycle 1).
    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts falling edges until frame_done is seen, bounded by budget.
    task automatic wait_done(input int budget, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (frame_done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, 32'(fb_rd_addr), 32'd0);
        chk({tag, "_data"}, 32'(pix_if.pix_data), 32'd0);
        chk({tag, "_valid"}, 32'(pix_if.pix_valid), 32'd0);
        chk({tag, "_sof"}, 32'(pix_if.pix_sof), 32'd0);
        chk({tag, "_eol"}, 32'(pix_if.pix_eol), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        fb_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Frame A: latency and full-rate throughput.
        pulse_start();
        @(negedge clk);
        chk("A_c1_busy", 32'(busy), 32'd1);
        chk("A_c1_addr", 32'(fb_rd_addr), 32'd0);
        chk("A_c1_valid", 32'(pix_if.pix_valid), 32'd0);
        @(negedge clk);
        chk("A_c2_addr", 32'(fb_rd_addr), 32'd1);
        chk("A_c2_valid", 32'(pix_if.pix_valid), 32'd0);
        @(negedge clk);
        chk("A_c3_valid", 32'(pix_if.pix_valid), 32'd1);
        chk("A_c3_sof", 32'(pix_if.pix_sof), 32'd1);
        chk("A_c3_data", 32'(pix_if.pix_data), 32'd0);
        chk("A_c3_addr", 32'(fb_rd_addr), 32'd2);
        @(negedge clk);
        chk("A_c4_data", 32'(pix_if.pix_data), 32'd1);
        chk("A_c4_sof", 32'(pix_if.pix_sof), 32'd0);
        wait_done(200, n);
        chk("A_done_cycle", 32'(n), 32'd63);
        @(negedge clk);
        chk("A_idle_addr", 32'(fb_rd_addr), 32'd0);
        chk("A_idle_done", 32'(frame_done), 32'd0);

        // Frame B: fb_ready low for 10 cycles, then dropped again mid-scan.
        @(posedge clk);
        #1 fb_ready = 1'b0;
        pulse_start();
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk("B_wait_valid", 32'(pix_if.pix_valid), 32'd0);
            chk("B_wait_addr", 32'(fb_rd_addr), 32'd0);
            @(posedge clk);
        end
        #1 fb_ready = 1'b1;
        @(negedge clk);
        chk("B_c10_valid", 32'(pix_if.pix_valid), 32'd0);
        @(negedge clk);
        chk("B_c11_addr", 32'(fb_rd_addr), 32'd0);
        chk("B_c11_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("B_c12_addr", 32'(fb_rd_addr), 32'd1);
        chk("B_c12_valid", 32'(pix_if.pix_valid), 32'd0);
        @(negedge clk);
        chk("B_c13_valid", 32'(pix_if.pix_valid), 32'd1);
        chk("B_c13_sof", 32'(pix_if.pix_sof), 32'd1);
        @(posedge clk);
        #1 fb_ready = 1'b0;
        wait_done(200, n);
        chk("B_done_cycle", 32'(n), 32'd64);
        fb_ready = 1'b1;

        // Frame C: stall until FIFO fills, single handshake, then random back-pressure.
        fb_key = 1;
        ready_mode = 0;
        @(posedge clk);
        pulse_start();
        repeat (8) @(negedge clk);
        chk("C_full_addr", 32'(fb_rd_addr), 32'd3);
        chk("C_full_valid", 32'(pix_if.pix_valid), 32'd1);
        chk("C_full_sof", 32'(pix_if.pix_sof), 32'd1);
        ready_mode = 1;
        @(posedge clk);
        #2 ready_mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk("C_resume_addr", 32'(fb_rd_addr), 32'd4);
        @(negedge clk);
        chk("C_hold_addr", 32'(fb_rd_addr), 32'd4);
        ready_mode = 2;
        repeat (20) @(posedge clk);
        pulse_start();
        wait_done(3000, n);

        // start held from the frame_done cycle: ignored there, honoured one cycle later.
        start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("D_start_on_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("D_busy", 32'(busy), 32'd1);
        chk("D_addr", 32'(fb_rd_addr), 32'd0);
        wait_done(3000, n);

        // Frame E: reset at pixel 20, then a clean restart.
        fb_key = 0;
        ready_mode = 1;
        @(posedge clk);
        pulse_start();
        repeat (22) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        pulse_start();
        @(negedge clk);
        chk("E_c1_addr", 32'(fb_rd_addr), 32'd0);
        chk("E_c1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("E_c3_valid", 32'(pix_if.pix_valid), 32'd1);
        chk("E_c3_sof", 32'(pix_if.pix_sof), 32'd1);
        chk("E_c3_data", 32'(pix_if.pix_data), 32'd0);
        wait_done(200, n);
        chk("E_done_cycle", 32'(n), 32'd64);

`ifdef FB_SCANNER_TEST_PATTERN_EN
        // Frame F: colour bars, test_pattern dropped after start to show it is latched.
        fb_key = 1;
        exp_tp = 1'b1;
        test_pattern = 1'b1;
        pulse_start();
        test_pattern = 1'b0;
        repeat (8) @(negedge clk);
        chk("F_px5_bar", 32'(pix_if.pix_data), 32'd2);
        wait_done(200, n);
        chk("F_done_cycle", 32'(n), 32'd59);
        exp_tp = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frame_buffer_scanner.md
# frame_buffer_scanner

Raster read engine directly downstream of `frame_buffer`. On a start pulse it walks the 640×400 4-bit frame buffer in raster order and drives the buffer's read address. It absorbs the buffer's 1-cycle read latency and presents the pixels as a valid/ready stream to the display serializer. Line and frame markers travel with each pixel, and a small skid FIFO ensures no pixel is lost or duplicated under back-pressure.

## Interface
- `H_ACTIVE`, 640: pixels per line.
- `V_ACTIVE`, 400: lines per frame; `H_ACTIVE*V_ACTIVE` must be ≤ 2^18.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥ 4.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle pulse that begins a frame; ignored while `busy`.
- `fb_ready` in 1: frame buffer RAM ready.
- `fb_rd_addr` out 18: linear read address to the frame buffer.
- `fb_rd_data` in 4: read data, valid exactly 1 cycle after its address.
- `pix_data` out 4: pixel value.
- `pix_valid` out 1: `pix_data`, `pix_sof` and `pix_eol` are valid.
- `pix_ready` in 1: sink accepts; a handshake is `pix_valid & pix_ready`.
- `pix_sof` out 1: qualifies the first pixel of the frame (x=0, y=0).
- `pix_eol` out 1: qualifies the last pixel of each line (x=`H_ACTIVE`-1).
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse after the final pixel handshake.

## Operation
- State machine:
  - IDLE: `start` → WAIT_RDY.
  - WAIT_RDY: `fb_ready` high → SCAN.
  - SCAN: after the last address (`H_ACTIVE*V_ACTIVE-1`, 255999 at defaults) is issued → DRAIN.
  - DRAIN: after the final handshake → IDLE, pulsing `frame_done`.
- Address generation:
  - Linear counter starts at 0 and increments by 1 per issued read; no multiplier.
  - Separate x/y counters track position; x wraps at `H_ACTIVE`, incrementing y.
- Issue rule: a read is issued in a cycle only when the state is SCAN and `fifo_count + inflight < FIFO_DEPTH`. `inflight` is 0 or 1, counting a read issued last cycle whose data has not yet been written.
- When no read is issued, `fb_rd_addr` holds its last value; in IDLE it is 0.
- Capture: read data is written into the FIFO together with `sof`/`eol` flags, which are delayed 1 cycle alongside the address.
- The FIFO never overflows. An underflow is impossible by construction.
- `fb_ready` dropping during SCAN has no effect. It is sampled only in WAIT_RDY.
- `start` asserted while `busy` is ignored. `start` in the same cycle as `frame_done` is ignored; it is honoured from the following cycle.
- `rst` at any point:
  - Returns to IDLE, clears counters, and empties the FIFO.
  - In-flight read data returning after reset is discarded.
- Reset values:
  - `fb_rd_addr`=0
  - `pix_data`=0
  - `pix_valid`=0
  - `pix_sof`=0
  - `pix_eol`=0
  - `busy`=0
  - `frame_done`=0

## Timing
- Pipeline with `start` in cycle 0 and `fb_ready` high:
  - Cycle 1: SCAN, `fb_rd_addr`=0.
  - Cycle 2: `fb_rd_data` captured.
  - Cycle 3: `pix_valid`=1 with `pix_sof`=1.
- `busy` rises in cycle 1 and falls together with the `frame_done` pulse.
- Throughput with `pix_ready` held high is 1 pixel/cycle. A full frame takes 256000 handshakes plus 3 cycles of latency.
- Back-pressure:
  - `pix_data`, `pix_sof` and `pix_eol` stay stable while `pix_valid & ~pix_ready`.
  - Issuing stalls within 1 cycle of the FIFO reaching its limit.
  - Issuing resumes the cycle after a handshake frees an entry.
- `pix_valid` never deasserts without a handshake.

## Configuration
- `FB_SCANNER_TEST_PATTERN_EN` defined:
  - Adds input `test_pattern` (1 bit), sampled at `start`, constant for the frame.
  - When set, FIFO write data is replaced by the bar index `x / (H_ACTIVE/8)`, giving values 0–7 (80 columns per bar at defaults).
  - Reads and timing are unchanged.
- Not defined: the port is absent and pixels always come from `fb_rd_data`.

## Test plan
- Full frame: with the buffer preloaded with `addr[3:0]`, `start` and `pix_ready`=1 → 256000 pixels, each with `pix_data`=index mod 16. `pix_sof` is asserted only on pixel 0, `pix_eol` on every 640th pixel, then one `frame_done` pulse.
- Latency: `start` in cycle 0 → `fb_rd_addr`=0 in cycle 1 and first `pix_valid` in cycle 3. Holding `fb_ready`=0 for 10 cycles delays both by 10 cycles.
- Back-pressure: random `pix_ready` at 30% duty → identical pixel sequence, no gaps or repeats. The FIFO never exceeds 4 entries, and outputs stay stable while stalled.
- Restart and ignore: `start` pulsed mid-frame → no effect. `start` immediately after `frame_done` → second frame identical to the first.
- Reset mid-frame: `rst` at pixel 1000 → all outputs are 0 and `busy`=0 on the next edge. A new `start` begins again at address 0 with `pix_sof`.
- Test pattern (macro defined, `test_pattern`=1): line 0 outputs 80×0, 80×1, …, 80×7. Every line is identical.
